// File: rtl/nios_system_pixel_pack_writer.sv
// -----------------------------------------------------------------------------
// nios_system_pixel_pack_writer
//
// Packs an 8-bit grayscale pixel stream (valid/ready) into 32-bit words, four
// pixels per word with pixel 0 in byte lane 0. Each word is written to the
// on-chip image RAM at consecutive word addresses starting at a programmed
// base. The RAM has no waitrequest, so every write completes in the cycle it
// is issued. A Nios core starts a tile with cfg_start and polls busy/done.
//
// Optional feature macro: PIXEL_WR_CHECKSUM_EN
//   defined   : checksum = sum of accepted pixels mod 2^16. It is cleared on an
//               accepted start and holds from the done pulse to the next start.
//   undefined : no checksum logic is built; checksum is tied to 16'h0000.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cfg_start           start pulse, only honoured in IDLE
//   cfg_base, cfg_npix  first word address / pixel count, latched on start
//   busy                high in FILL, WRITE and DONE
//   done                one-cycle pulse at the end of a tile
//   err_wrap            sticky: address incremented past 2^ADDR_W-1
//   checksum            pixel sum (see macro above)
//   px_data/px_valid/px_ready   pixel stream, accepted on valid & ready
//   mem_*               Avalon-style RAM write port, mem_clken constant 1
// -----------------------------------------------------------------------------
module nios_system_pixel_pack_writer #(
   parameter int ADDR_W = 14,
   parameter int NPIX_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [NPIX_W-1:0] cfg_npix,
   output logic              busy,
   output logic              done,
   output logic              err_wrap,
   output logic [15:0]       checksum,
   input  logic [7:0]        px_data,
   input  logic              px_valid,
   output logic              px_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t state_reg, state_next;

   logic [ADDR_W-1:0] addr_reg;
   logic [NPIX_W-1:0] rem_reg;
   logic [1:0]        lane_reg;
   logic              err_wrap_reg;

   // Handshake qualifiers shared by the FSM and the datapath.
   logic start_ok;
   logic px_fire;
   logic word_full;
   logic in_write;

   assign start_ok  = (state_reg == ST_IDLE) && cfg_start;
   assign px_fire   = (state_reg == ST_FILL) && px_valid;
   assign in_write  = (state_reg == ST_WRITE);
   // The pixel being accepted closes the word if it lands in lane 3 or if it
   // is the last pixel of the tile (rem is decremented by this same pixel).
   assign word_full = (lane_reg == 2'd3) || (rem_reg == NPIX_W'(1));

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next state and Moore outputs. All strobes decode straight from the
   // state register, so a reset leaves IDLE and no strobe in the next cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      busy           = 1'b0;
      done           = 1'b0;
      px_ready       = 1'b0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (cfg_start) begin
               state_next = (cfg_npix == '0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            busy     = 1'b1;
            px_ready = 1'b1;
            if (px_valid && word_full) begin
               state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            busy           = 1'b1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            state_next     = (rem_reg == '0) ? ST_DONE : ST_FILL;
         end
         ST_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Address, remaining-pixel count, lane pointer and wrap flag
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_reg     <= '0;
         rem_reg      <= '0;
         lane_reg     <= 2'd0;
         err_wrap_reg <= 1'b0;
      end else if (start_ok) begin
         addr_reg     <= cfg_base;
         rem_reg      <= cfg_npix;
         lane_reg     <= 2'd0;
         err_wrap_reg <= 1'b0;
      end else if (px_fire) begin
         rem_reg  <= rem_reg - NPIX_W'(1);
         lane_reg <= lane_reg + 2'd1;
      end else if (in_write) begin
         // The address advances after every word, including the last one, so
         // a tile ending exactly at the top of memory also flags the wrap.
         addr_reg <= addr_reg + ADDR_W'(1);
         lane_reg <= 2'd0;
         if (&addr_reg) begin
            err_wrap_reg <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Per-lane pixel byte and byte-enable. A lane never written in the current
   // word stays zero, so unused lanes of a partial final word read as 0.
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] byte_reg;
         logic       be_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               byte_reg <= 8'h00;
               be_reg   <= 1'b0;
            end else if (start_ok || in_write) begin
               byte_reg <= 8'h00;
               be_reg   <= 1'b0;
            end else if (px_fire && (lane_reg == 2'(gi))) begin
               byte_reg <= px_data;
               be_reg   <= 1'b1;
            end
         end

         assign mem_writedata[gi*8 +: 8] = byte_reg;
         assign mem_byteenable[gi]       = be_reg;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Optional running checksum
   // -------------------------------------------------------------------------
`ifdef PIXEL_WR_CHECKSUM_EN
   logic [15:0] sum_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_reg <= 16'h0000;
      end else if (start_ok) begin
         sum_reg <= 16'h0000;
      end else if (px_fire) begin
         sum_reg <= sum_reg + {8'h00, px_data};
      end
   end

   assign checksum = sum_reg;
`else
   assign checksum = 16'h0000;
`endif

   assign mem_address = addr_reg;
   assign err_wrap    = err_wrap_reg;
   assign mem_clken   = 1'b1;

endmodule
